seg7_scan_driver: RTL and testbench

//  Drives the board's 4-digit multiplexed 7-segment display (AN/BCD) from a 16-bit hex value written by the CPU.

---
 rtl/seg7_scan_driver.sv | 190 +++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Scans a 4-digit multiplexed 7-segment display from a 16-bit hex value
//   written over the CPU peripheral bus. The value is double-buffered: a CPU
//   write lands in a pending buffer and only becomes visible at the next
//   digit3->digit0 wrap, so a frame never shows a mix of old and new digits.
//
// Parameters
//   CLK_DIV    clk cycles per digit slot (>= 2); one frame = 4*CLK_DIV cycles
//   BLANK_LZ   1: dark leading-zero digits 3..1 (digit 0 always lit)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   enable      1: scan the display, 0: all digits dark, scan held at digit 0
//   wr_en       single-cycle write strobe
//   wr_data     hex value, nibble k drives digit k (digit 0 = rightmost)
//   wr_dp       decimal point per digit (1 = lit), captured with wr_data
//   AN          anode selects, active-low, one-hot-low while scanning
//   BCD         segments {dp,g,f,e,d,c,b,a}, active-low
//   frame_done  one-cycle pulse following each digit3->digit0 wrap
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int unsigned CLK_DIV  = 100000,
    parameter bit          BLANK_LZ = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    output logic [3:0]  AN,
    output logic [7:0]  BCD,
    output logic        frame_done
);

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Scan position
    logic [DIV_W-1:0]  div_cnt;
    logic [IDX_W-1:0]  idx;

    // Visible and pending display buffers
    logic [DATA_W-1:0] shown_val;
    logic [DIGITS-1:0] shown_dp;
    logic [DATA_W-1:0] pend_val;
    logic [DIGITS-1:0] pend_dp;
    logic              pend_vld;

    // Combinational decode of the current slot
    logic              slot_end_c;
    logic              frame_end_c;
    logic [NIB_W-1:0]  cur_nib_c;
    logic              cur_dp_c;
    logic              upper_zero_c;
    logic              blank_c;
    logic [SEG_W-1:0]  seg_c;
    logic [DIGITS-1:0] an_c;

    // Hex digit to active-low {g,f,e,d,c,b,a}
    function automatic logic [SEG_W-1:0] hex_seg(input logic [NIB_W-1:0] nib);
        logic [SEG_W-1:0] seg;
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Slot / frame boundary detection
    always_comb begin
        slot_end_c  = enable && (div_cnt == DIV_LAST);
        frame_end_c = slot_end_c && (idx == IDX_LAST);
    end

    // Select the nibble for the current digit and decide leading-zero blanking
    always_comb begin
        cur_nib_c    = shown_val[3:0];
        upper_zero_c = 1'b0;
        case (idx)
            2'd0: begin
                cur_nib_c    = shown_val[3:0];
                upper_zero_c = 1'b0;
            end
            2'd1: begin
                cur_nib_c    = shown_val[7:4];
                upper_zero_c = (shown_val[15:4] == 12'h000);
            end
            2'd2: begin
                cur_nib_c    = shown_val[11:8];
                upper_zero_c = (shown_val[15:8] == 8'h00);
            end
            default: begin
                cur_nib_c    = shown_val[15:12];
                upper_zero_c = (shown_val[15:12] == 4'h0);
            end
        endcase
        cur_dp_c = shown_dp[idx];
        // A lit decimal point keeps its digit visible even when it is a leading zero
        blank_c  = BLANK_LZ && (idx != 2'd0) && !cur_dp_c && upper_zero_c;
        seg_c    = hex_seg(cur_nib_c);
        an_c     = ~(DIGITS'(1) << idx);
    end

    // Refresh divider and digit index; held at slot 0 while disabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt    <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else if (!enable) begin
            div_cnt    <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end_c;
            if (slot_end_c) begin
                div_cnt <= '0;
                idx     <= idx + IDX_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Double buffer: writes wait in pending until the frame wraps; while the
    // display is dark there is no frame to tear, so commits are immediate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shown_val <= '0;
            shown_dp  <= '0;
            pend_val  <= '0;
            pend_dp   <= '0;
            pend_vld  <= 1'b0;
        end else if (!enable || frame_end_c) begin
            if (wr_en) begin
                shown_val <= wr_data;
                shown_dp  <= wr_dp;
            end else if (pend_vld) begin
                shown_val <= pend_val;
                shown_dp  <= pend_dp;
            end
            pend_vld <= 1'b0;
        end else if (wr_en) begin
            pend_val <= wr_data;
            pend_dp  <= wr_dp;
            pend_vld <= 1'b1;
        end
    end

    // Registered pin drive, one cycle behind the scan index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            AN  <= 4'hF;
            BCD <= 8'hFF;
        end else if (!enable || blank_c) begin
            AN  <= 4'hF;
            BCD <= 8'hFF;
        end else begin
            AN  <= an_c;
            BCD <= {~cur_dp_c, seg_c};
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: two instances (BLANK_LZ=0/1, CLK_DIV=4)
// compared every cycle against a frame-time reference model, plus a table of
// static display vectors and hand-written multi-cycle corner cases.
module tb_seg7_scan_driver;

    localparam int FRAME = 16;
    localparam int SLOT  = 4;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic [3:0]  an0, an1;
    logic [7:0]  bcd0, bcd1;
    logic        fd0, fd1;

    int n_chk  = 0;
    int n_pass = 0;

    seg7_scan_driver #(.CLK_DIV(4), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en),
        .wr_data(wr_data), .wr_dp(wr_dp), .AN(an0), .BCD(bcd0), .frame_done(fd0));

    seg7_scan_driver #(.CLK_DIV(4), .BLANK_LZ(1'b1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en),
        .wr_data(wr_data), .wr_dp(wr_dp), .AN(an1), .BCD(bcd1), .frame_done(fd1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment table from the display's hex rules (dp off)
    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: time since scan start, visible and pending values
    int          m_t;
    logic [15:0] m_val, m_pval;
    logic [3:0]  m_dp, m_pdp;
    bit          m_pvld;
    logic [3:0]  e_an0, e_an1;
    logic [7:0]  e_bcd0, e_bcd1;
    logic        e_fd;

    function automatic logic [11:0] disp(input logic [15:0] v, input logic [3:0] dp,
                                         input int k, input bit blz);
        logic [15:0] upper;
        logic [3:0]  an_v;
        logic [7:0]  bcd_v;
        int          nib;
        upper = v >> (4 * k);
        nib   = int'(upper & 16'h000F);
        if (blz && k >= 1 && !dp[k] && upper == 16'h0000) return {4'hF, 8'hFF};
        an_v  = ~(4'b0001 << k);
        bcd_v = (seg_tbl[nib] & 8'h7F) | (dp[k] ? 8'h00 : 8'h80);
        return {an_v, bcd_v};
    endfunction

    task automatic model_reset();
        m_t = 0; m_val = '0; m_pval = '0; m_dp = '0; m_pdp = '0; m_pvld = 0;
        e_an0 = 4'hF; e_an1 = 4'hF; e_bcd0 = 8'hFF; e_bcd1 = 8'hFF; e_fd = 1'b0;
    endtask

    task automatic model_edge();
        bit boundary;
        int dig;
        boundary = enable && (m_t % FRAME == FRAME - 1);
        if (enable) begin
            dig = (m_t / SLOT) % 4;
            {e_an0, e_bcd0} = disp(m_val, m_dp, dig, 1'b0);
            {e_an1, e_bcd1} = disp(m_val, m_dp, dig, 1'b1);
            e_fd = boundary;
        end else begin
            e_an0 = 4'hF; e_an1 = 4'hF; e_bcd0 = 8'hFF; e_bcd1 = 8'hFF; e_fd = 1'b0;
        end
        if (!enable || boundary) begin
            if (wr_en) begin
                m_val = wr_data; m_dp = wr_dp;
            end else if (m_pvld) begin
                m_val = m_pval; m_dp = m_pdp;
            end
            m_pvld = 0;
        end else if (wr_en) begin
            m_pval = wr_data; m_pdp = wr_dp; m_pvld = 1;
        end
        m_t = enable ? m_t + 1 : 0;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic compare_all();
        chk("an_blz0",  16'(an0),  16'(e_an0));
        chk("bcd_blz0", 16'(bcd0), 16'(e_bcd0));
        chk("fd_blz0",  16'(fd0),  16'(e_fd));
        chk("an_blz1",  16'(an1),  16'(e_an1));
        chk("bcd_blz1", 16'(bcd1), 16'(e_bcd1));
        chk("fd_blz1",  16'(fd1),  16'(e_fd));
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge
    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_until(input int phase);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (m_t % FRAME == phase) break;
        end
    endtask

    typedef struct {
        string       name;
        logic [15:0] val;
        logic [3:0]  dp;
        bit          blz;
        int          digit;
        logic [3:0]  an;
        logic [7:0]  bcd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"dp2_lit",      16'h0000, 4'b0100, 1'b0, 2, 4'hB, 8'h40};
        vecs[1]  = '{"dp2_d0",       16'h0000, 4'b0100, 1'b0, 0, 4'hE, 8'hC0};
        vecs[2]  = '{"blz_0050_d3",  16'h0050, 4'b0000, 1'b1, 3, 4'hF, 8'hFF};
        vecs[3]  = '{"blz_0050_d2",  16'h0050, 4'b0000, 1'b1, 2, 4'hF, 8'hFF};
        vecs[4]  = '{"blz_0050_d1",  16'h0050, 4'b0000, 1'b1, 1, 4'hD, 8'h92};
        vecs[5]  = '{"blz_0050_d0",  16'h0050, 4'b0000, 1'b1, 0, 4'hE, 8'hC0};
        vecs[6]  = '{"hex_12AF_d0",  16'h12AF, 4'b0000, 1'b0, 0, 4'hE, 8'h8E};
        vecs[7]  = '{"hex_12AF_d1",  16'h12AF, 4'b0000, 1'b0, 1, 4'hD, 8'h88};
        vecs[8]  = '{"hex_12AF_d2",  16'h12AF, 4'b0000, 1'b0, 2, 4'hB, 8'hA4};
        vecs[9]  = '{"hex_12AF_d3",  16'h12AF, 4'b0000, 1'b0, 3, 4'h7, 8'hF9};
        vecs[10] = '{"blz_dp3_kept", 16'h0000, 4'b1000, 1'b1, 3, 4'h7, 8'h40};
        vecs[11] = '{"noblz_0050_d3",16'h0050, 4'b0000, 1'b0, 3, 4'h7, 8'hC0};

        reset = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_data = '0; wr_dp = '0;
        model_reset();
        @(negedge clk);
        compare_all();
        step();
        step();

        // Free-running scan of the reset value
        reset = 1'b1; enable = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) step();

        // Static display vectors: load while dark, then scan to the digit
        foreach (vecs[v]) begin
            enable = 1'b0; wr_en = 1'b1; wr_data = vecs[v].val; wr_dp = vecs[v].dp;
            step();
            wr_en = 1'b0; enable = 1'b1;
            repeat (SLOT * vecs[v].digit + 2) step();
            chk({vecs[v].name, "_an"},  16'(vecs[v].blz ? an1 : an0),   16'(vecs[v].an));
            chk({vecs[v].name, "_bcd"}, 16'(vecs[v].blz ? bcd1 : bcd0), 16'(vecs[v].bcd));
        end

        // Write coinciding with the frame boundary shows from digit 0
        run_until(FRAME - 1);
        wr_en = 1'b1; wr_data = 16'h0003; wr_dp = 4'b0000;
        step();
        wr_en = 1'b0;
        chk("boundary_fd", 16'(fd0), 16'h0001);
        step();
        chk("boundary_an", 16'(an0), 16'h000E);
        chk("boundary_bcd", 16'(bcd0), 16'h00B0);

        // Disable mid-frame, then re-enable for a full slot on digit 0
        run_until(6);
        enable = 1'b0;
        step();
        chk("dis_an", 16'(an0), 16'h000F);
        chk("dis_bcd", 16'(bcd0), 16'h00FF);
        step();
        enable = 1'b1;
        for (int i = 0; i < SLOT; i++) begin
            step();
            chk("reen_slot0_an", 16'(an0), 16'h000E);
        end
        step();
        chk("reen_slot1_an", 16'(an0), 16'h000D);

        // Async reset between edges with a write pending
        run_until(9);
        wr_en = 1'b1; wr_data = 16'hBEEF; wr_dp = 4'b1111;
        step();
        wr_en = 1'b0;
        step();
        #2 reset = 1'b0;
        #1;
        chk("async_rst_an0",  16'(an0),  16'h000F);
        chk("async_rst_bcd0", 16'(bcd0), 16'h00FF);
        chk("async_rst_fd0",  16'(fd0),  16'h0000);
        chk("async_rst_an1",  16'(an1),  16'h000F);
        step();
        reset = 1'b1;
        run_until(2);
        chk("post_rst_d0_bcd", 16'(bcd0), 16'h00C0);

        // Mid-frame write at digit 1 slot position 1 waits for the next frame
        run_until(5);
        wr_en = 1'b1; wr_data = 16'h12AF; wr_dp = 4'b0000;
        step();
        wr_en = 1'b0;
        run_until(14);
        chk("midframe_old_d3", 16'(bcd0), 16'h00C0);
        run_until(14);
        chk("nextframe_new_d3", 16'(bcd0), 16'h00F9);

        // Two writes in one frame: last one wins
        run_until(2);
        wr_en = 1'b1; wr_data = 16'h1111;
        step();
        wr_en = 1'b0;
        run_until(8);
        wr_en = 1'b1; wr_data = 16'h2222;
        step();
        wr_en = 1'b0;
        run_until(14);
        run_until(2);
        chk("last_write_wins", 16'(bcd0), 16'h00A4);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            enable  = ($urandom_range(0, 19) != 0);
            wr_en   = ($urandom_range(0, 9) == 0);
            wr_data = 16'($urandom);
            if ($urandom_range(0, 3) == 0) wr_data = wr_data & 16'h00FF;
            wr_dp   = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            reset   = ($urandom_range(0, 499) != 0);
            step();
        end
        reset = 1'b1; enable = 1'b1; wr_en = 1'b0;
        for (int i = 0; i < FRAME; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
